flipflop_pipe: RTL and testbench
================================

// Module: flipflop_pipe
// PURPOSE
//  Parametrised, back-pressured register pipeline; the successor to the plain 4-bit D flip-flop.
//  Carries WIDTH-bit words through DEPTH stages under a valid/ready handshake.
//  Empty stages (bubbles) collapse while the output is stalled.
//  Sits between producer and consumer blocks as a retiming and elastic buffer.
// PARAMETERS
//  WIDTH      4     data word width in bits (>=1)
//  DEPTH      3     number of register stages (>=1); DEPTH=1 is a single elastic flop
//  RESET_DATA 0     value loaded into every data register on reset
// PORTS
//  clk        in   1              rising-edge clock, sole clock domain
//  rst_n      in   1              synchronous reset, active low
//  flush      in   1              synchronous clear of all stage valid bits
//  in_valid   in   1              producer presents d this cycle
//  in_ready   out  1              pipeline accepts d this cycle
//  d          in   WIDTH          input word
//  out_valid  out  1              q holds a valid word
//  out_ready  in   1              consumer takes q this cycle
//  q          out  WIDTH          output word (last stage register)
//  count      out  $clog2(DEPTH+1) number of valid stages, 0..DEPTH
// BEHAVIOUR
//  - Reset: the reset is sampled on a clk rising edge with rst_n=0.
//    - All stage valid bits are cleared and all data registers are set to RESET_DATA.
//    - Resulting outputs: out_valid=0, q=RESET_DATA, count=0.
//    - in_ready=0 while rst_n=0.
//    - Reset mid-stream discards all contents; no word is output after reset.
//  - Stage 0 is the input stage and stage DEPTH-1 drives q/out_valid.
//    - rdy[DEPTH] = out_ready
//    - rdy[i] = !v[i] | rdy[i+1]; this is a combinational chain with no registered ready.
//    - in_ready = rdy[0] & rst_n & !flush.
//  - Stage i>0 loads d_i<=d_{i-1} and v_i<=v_{i-1} when rdy[i]=1.
//  - Stage 0 loads d and in_valid when rdy[0]=1.
//  - A stage not enabled holds its data and valid bit.
//  - Data registers load only when their incoming valid=1, so bubbles do not toggle data.
//  - A transfer occurs on the in side when in_valid&in_ready, and on the out side when out_valid&out_ready.
//  - No word is dropped or duplicated.
//  - Latency: a word accepted at edge N appears on q with out_valid=1 after edge N+DEPTH-1, provided there is no stall.
//    - Throughput is one word per clock with out_ready held at 1.
//  - Full: all v=1 and out_ready=0 gives in_ready=0.
//    - All v=1 and out_ready=1 gives in_ready=1; a simultaneous in and out transfer is allowed when full.
//  - Empty: a word travels to the first free stage at one stage per clock.
//    - out_valid=0 and q holds its last value.
//  - Stall: out_ready=0 with out_valid=1 means q and out_valid are held stable until the transfer happens.
//  - count: registered, and updated every edge.
//    - +1 on an in transfer only.
//    - -1 on an out transfer only.
//    - Unchanged on both or neither.
//    - count saturates by construction at DEPTH; it is never >DEPTH.
//  - flush=1 at an edge clears all v bits and sets count to 0; data registers are untouched.
//    - in_ready=0 during flush, so no input is accepted that cycle.
//    - An out transfer in the flush cycle still counts as consumed.
//  - rst_n has priority over flush.
//  - No combinational path from d to q. in_ready depends combinationally on out_ready.
// TESTING
//  - Reset: rst_n=0 for 2 clk, in_valid=1, d=4'hF.
//    Required: q=0, out_valid=0, count=0, in_ready=0; after rst_n=1, in_ready=1.
//  - Stream: WIDTH=4, DEPTH=3, out_ready=1; send 4'h3, 4'h7, 4'hE, 4'hA on consecutive edges.
//    Required: q shows 3, 7, E, A with out_valid=1 starting 2 edges after the first accept.
//  - Backpressure: out_ready=0, in_valid=1 with d=1,2,3,4.
//    Required: count reaches 3, in_ready=0, q=1 held.
//    Then out_ready=1: outputs 1, 2, 3, 4 in order, and d=4 is accepted in the same cycle as the first out.
//  - Bubble collapse: send a single word 4'h7, hold out_ready=0 for 5 clk.
//    Required: 4'h7 reaches stage 2, then in_ready stays 1 until 3 words are held.
//  - Flush: full pipeline (count=3) with flush=1 for 1 clk.
//    Required: next cycle out_valid=0, count=0, in_ready=1; a subsequent 4'hA emerges alone.
//  - Reset mid-operation: rst_n=0 for 1 clk while count=2.
//    Required: no stale word ever appears on q with out_valid=1; q=RESET_DATA.

Source files
------------

// File: rtl/flipflop_pipe.sv
// Elastic WIDTH x DEPTH register pipeline with valid/ready handshake; bubbles collapse under stall.
// Latency DEPTH-1 edges from accept to q when unstalled; ready ripples combinationally from out_ready.
// Backpressure: a stage advances when it is empty or its successor advances; in_ready drops only when full and stalled.
module flipflop_pipe #(
    parameter int              WIDTH      = 4,
    parameter int              DEPTH      = 3,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             d,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             q,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] dat [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic             in_xfer;
    logic             out_xfer;

    // Ready chain built with a running variable so no vector bit reads a sibling bit.
    always_comb begin
        logic r;
        r   = out_ready;
        rdy = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            r      = !v[i] | r;
            rdy[i] = r;
        end
    end

    assign in_ready  = rdy[0] & rst_n & !flush;
    assign out_valid = v[DEPTH-1];
    assign q         = dat[DEPTH-1];
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v     <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat[i] <= RESET_DATA;
            end
        end else if (flush) begin
            // Data stays put; only occupancy is dropped.
            v     <= '0;
            count <= '0;
        end else begin
            if (rdy[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    dat[0] <= d;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        dat[i] <= dat[i-1];
                    end
                end
            end
            if (in_xfer && !out_xfer) begin
                count <= count + CW'(1);
            end else if (out_xfer && !in_xfer) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_flipflop_pipe.sv
// Directed bench for flipflop_pipe with WIDTH=4, DEPTH=3, RESET_DATA=0.
module tb_flipflop_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] d = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] q;
    logic [1:0] count;

    int checks = 0;
    int errors = 0;

    flipflop_pipe #(.WIDTH(4), .DEPTH(3), .RESET_DATA(4'h0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .q(q), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; d = 4'hF; out_ready = 1'b1;
        tick; tick;
        checks++; if (q !== 4'h0) begin errors++; $display("FAIL reset_q got %h want 0", q); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_stream;
        logic [3:0] vec [4];
        logic       exp_v;
        vec = '{4'h3, 4'h7, 4'hE, 4'hA};
        out_ready = 1'b1; in_valid = 1'b1; d = vec[0];
        for (int k = 0; k < 7; k++) begin
            tick;
            if (k + 1 < 4) d = vec[k+1];
            else in_valid = 1'b0;
            exp_v = (k >= 2) && (k <= 5);
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL stream_valid edge %0d got %b want %b", k, out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (q !== vec[k-2]) begin errors++; $display("FAIL stream_q edge %0d got %h want %h", k, q, vec[k-2]); end
            end
        end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL stream_count_end got %0d want 0", count); end
    endtask

    task automatic test_backpressure;
        logic [3:0] exp_q [3];
        logic [1:0] exp_c [3];
        exp_q = '{4'h2, 4'h3, 4'h4};
        exp_c = '{2'd3, 2'd2, 2'd1};
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            d = 4'(k);
            tick;
        end
        d = 4'h4;
        #1;
        checks++; if (count !== 2'd3) begin errors++; $display("FAIL bp_count_full got %0d want 3", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got %b want 0", in_ready); end
        checks++; if (q !== 4'h1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_head got q=%h v=%b want q=1 v=1", q, out_valid); end
        tick; tick;
        checks++; if (q !== 4'h1 || count !== 2'd3) begin errors++; $display("FAIL bp_hold got q=%h count=%0d want q=1 count=3", q, count); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release got %b want 1", in_ready); end
        for (int k = 0; k < 3; k++) begin
            tick;
            in_valid = 1'b0;
            checks++; if (q !== exp_q[k] || out_valid !== 1'b1 || count !== exp_c[k]) begin
                errors++; $display("FAIL bp_drain %0d got q=%h v=%b count=%0d want q=%h v=1 count=%0d", k, q, out_valid, count, exp_q[k], exp_c[k]);
            end
        end
        tick;
        checks++; if (out_valid !== 1'b0 || count !== 2'd0 || q !== 4'h4) begin
            errors++; $display("FAIL bp_empty got v=%b count=%0d q=%h want v=0 count=0 q=4", out_valid, count, q);
        end
    endtask

    task automatic test_bubble_collapse;
        out_ready = 1'b0; in_valid = 1'b1; d = 4'h7;
        tick;
        in_valid = 1'b0;
        tick; tick;
        checks++; if (q !== 4'h7 || out_valid !== 1'b1 || count !== 2'd1) begin
            errors++; $display("FAIL bubble_head got q=%h v=%b count=%0d want q=7 v=1 count=1", q, out_valid, count);
        end
        tick; tick;
        in_valid = 1'b1; d = 4'h8;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_rdy_1 got %b want 1", in_ready); end
        tick;
        d = 4'h9;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_rdy_2 got %b want 1", in_ready); end
        tick;
        d = 4'hB;
        #1;
        checks++; if (in_ready !== 1'b0 || count !== 2'd3 || q !== 4'h7) begin
            errors++; $display("FAIL bubble_full got rdy=%b count=%0d q=%h want rdy=0 count=3 q=7", in_ready, count, q);
        end
    endtask

    task automatic test_flush;
        flush = 1'b1; in_valid = 1'b1; d = 4'h5;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
        tick;
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_after got v=%b count=%0d rdy=%b want v=0 count=0 rdy=1", out_valid, count, in_ready);
        end
        checks++; if (q !== 4'h7) begin errors++; $display("FAIL flush_data_kept got %h want 7", q); end
        in_valid = 1'b1; d = 4'hA; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_stale_1 got %b want 0", out_valid); end
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_stale_2 got %b want 0", out_valid); end
        tick;
        checks++; if (out_valid !== 1'b1 || q !== 4'hA || count !== 2'd1) begin
            errors++; $display("FAIL flush_word got v=%b q=%h count=%0d want v=1 q=a count=1", out_valid, q, count);
        end
        tick;
        checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin
            errors++; $display("FAIL flush_alone got v=%b count=%0d want v=0 count=0", out_valid, count);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0; in_valid = 1'b1; d = 4'h1;
        tick;
        d = 4'h2;
        tick;
        in_valid = 1'b0;
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL rmid_count got %0d want 2", count); end
        rst_n = 1'b0;
        tick;
        checks++; if (q !== 4'h0 || out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rmid_reset got q=%h v=%b count=%0d rdy=%b want q=0 v=0 count=0 rdy=0", q, out_valid, count, in_ready);
        end
        rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++; if (out_valid !== 1'b0 || q !== 4'h0) begin
                errors++; $display("FAIL rmid_stale %0d got v=%b q=%h want v=0 q=0", k, out_valid, q);
            end
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_bubble_collapse;
        test_flush;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
